// File: rtl/run_length_detector.sv
// Run-length detector on a serial bit stream.
// Tracks the polarity and saturating length of the current run of identical
// accepted samples, flags long runs of ones/zeros against independent
// thresholds, and emits a one-cycle hit pulse plus a saturating hit count
// each time an enabled threshold is first reached within a run.
module run_length_detector #(
  parameter int unsigned ONES_LEN  = 4,
  parameter int unsigned ZEROS_LEN = 4,
  parameter int unsigned HIT_W     = 8,
  parameter int unsigned RESET_HOT = 1,
  localparam int unsigned MAXLEN   = (ONES_LEN > ZEROS_LEN) ? ONES_LEN : ZEROS_LEN,
  localparam int unsigned CNT_W    = $clog2(MAXLEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic             z,
  output logic             z_ones,
  output logic             z_zeros,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_len,
  output logic             hit,
  output logic [HIT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] OnesLenC  = CNT_W'(ONES_LEN);
  localparam logic [CNT_W-1:0] ZerosLenC = CNT_W'(ZEROS_LEN);
  localparam logic [CNT_W-1:0] MaxLenC   = CNT_W'(MAXLEN);
  localparam logic [CNT_W-1:0] OneC      = CNT_W'(1);
  // A "hot" reset behaves as if a full zero run had already been seen.
  localparam logic [CNT_W-1:0] RstLenC   = (RESET_HOT != 0) ? ZerosLenC : '0;
  localparam logic [HIT_W-1:0] HitMaxC   = '1;

  logic             run_bit_q, run_bit_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             hit_q, hit_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             grew;
  logic             ones_reach;
  logic             zeros_reach;

  // Next-state: clear wins, otherwise advance or restart the run on accepted samples.
  always_comb begin
    run_bit_d   = run_bit_q;
    run_len_d   = run_len_q;
    hit_d       = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    grew        = 1'b0;
    ones_reach  = 1'b0;
    zeros_reach = 1'b0;
    if (clr) begin
      run_bit_d = 1'b0;
      run_len_d = RstLenC;
      hit_cnt_d = '0;
    end else if (en) begin
      // A zero length (cold reset) means no run yet: any sample starts one.
      if ((run_len_q == '0) || (w != run_bit_q)) begin
        run_bit_d = w;
        run_len_d = OneC;
        grew      = 1'b1;
      end else if (run_len_q != MaxLenC) begin
        run_len_d = run_len_q + OneC;
        grew      = 1'b1;
      end
      // Only a length that actually changed can reach a threshold, so a
      // saturated run (or the hot reset state) never re-triggers.
      ones_reach  = run_bit_d & (run_len_d == OnesLenC) & mode[0];
      zeros_reach = ~run_bit_d & (run_len_d == ZerosLenC) & mode[1];
      hit_d       = grew & (ones_reach | zeros_reach);
      if (hit_d && (hit_cnt_q != HitMaxC)) begin
        hit_cnt_d = hit_cnt_q + HIT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_bit_q <= 1'b0;
      run_len_q <= RstLenC;
      hit_q     <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      run_bit_q <= run_bit_d;
      run_len_q <= run_len_d;
      hit_q     <= hit_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  // Moore outputs decoded from registered run state; mode masks only z.
  always_comb begin
    z_ones  = run_bit_q & (run_len_q >= OnesLenC);
    z_zeros = ~run_bit_q & (run_len_q >= ZerosLenC);
    z       = (z_ones & mode[0]) | (z_zeros & mode[1]);
    run_bit = run_bit_q;
    run_len = run_len_q;
    hit     = hit_q;
    hit_cnt = hit_cnt_q;
  end

endmodule
